// File: rtl/mac_dot_sequencer_pkg.sv
// Shared definitions for the MAC dot-product operand sequencer.
// Holds the FSM state encoding and the default field widths.
package mac_dot_sequencer_pkg;

    localparam int DEF_LEN_W  = 8;
    localparam int DEF_DATA_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mac_dot_sequencer.sv
// Streams operand pairs into an external combinational MAC and
// feeds each MAC result back as the next addend.
module mac_dot_sequencer
    import mac_dot_sequencer_pkg::*;
#(
    parameter int LEN_W  = DEF_LEN_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_cmd_valid,
    output logic              io_cmd_ready,
    input  logic [LEN_W-1:0]  io_cmd_len,
    input  logic [DATA_W-1:0] io_cmd_bias,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [DATA_W-1:0] io_in_a,
    input  logic [DATA_W-1:0] io_in_b,
    output logic [DATA_W-1:0] io_mac_a,
    output logic [DATA_W-1:0] io_mac_b,
    output logic [DATA_W-1:0] io_mac_c,
    input  logic [DATA_W-1:0] io_mac_out,
    output logic              io_res_valid,
    input  logic              io_res_ready,
    output logic [DATA_W-1:0] io_res_bits,
    output logic              io_busy
);

    logic [1:0]        state;
    logic [DATA_W-1:0] acc;
    logic [LEN_W-1:0]  cnt;

    logic cmd_fire;
    logic in_fire;
    logic res_fire;

    assign cmd_fire = io_cmd_valid & io_cmd_ready;
    assign in_fire  = io_in_valid & io_in_ready;
    assign res_fire = io_res_valid & io_res_ready;

    // Handshake and datapath outputs; everything held at zero in reset.
    always_comb begin
        io_cmd_ready = 1'b0;
        io_in_ready  = 1'b0;
        io_res_valid = 1'b0;
        io_res_bits  = '0;
        io_mac_a     = '0;
        io_mac_b     = '0;
        io_mac_c     = '0;
        io_busy      = 1'b0;
        if (!reset) begin
            io_mac_c = acc;
            io_busy  = (state != ST_IDLE);
            case (state)
                ST_IDLE: io_cmd_ready = 1'b1;
                ST_RUN: begin
                    io_in_ready = 1'b1;
                    io_mac_a    = io_in_a;
                    io_mac_b    = io_in_b;
                end
                ST_DONE: begin
                    io_res_valid = 1'b1;
                    io_res_bits  = acc;
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, accumulator and remaining-element counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        acc   <= io_cmd_bias;
                        cnt   <= io_cmd_len;
                        state <= (io_cmd_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_fire) begin
                        acc <= io_mac_out;
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_fire) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Operand sequencer that feeds the FP16MAC-stage multiply-accumulate unit in the PIM datapath. It accepts a dot-product command (element count and bias), then streams operand pairs into the MAC one per cycle. Each MAC result is fed back as the next addend, and the final accumulated value is returned over a valid/ready result port. The MAC itself is combinational and lives outside this block. This block drives its a/b/c inputs and consumes its output.

## Interface
- LEN_W, 8, width of the element-count field
- DATA_W, 16, operand/accumulator width; must match the MAC
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- io_cmd_valid  in  1  command offered
- io_cmd_ready  out  1  command accepted when both valid and ready are high
- io_cmd_len  in  LEN_W  element count N; 0 allowed
- io_cmd_bias  in  DATA_W  initial accumulator value
- io_in_valid  in  1  operand pair offered
- io_in_ready  out  1  operand pair accepted
- io_in_a, io_in_b  in  DATA_W  operands
- io_mac_a, io_mac_b, io_mac_c  out  DATA_W  to MAC inputs
- io_mac_out  in  DATA_W  MAC result, (a*b+c) mod 2^16
- io_res_valid  out  1  result available
- io_res_ready  in  1  result consumed
- io_res_bits  out  DATA_W  accumulated result
- io_busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, RUN, DONE. Registers: state, acc (DATA_W), cnt (LEN_W).
- IDLE:
  - io_cmd_ready=1.
  - On command fire: acc<=bias and cnt<=len.
  - If len==0, go to DONE. Otherwise go to RUN.
- RUN:
  - io_in_ready=1.
  - io_mac_a=io_in_a, io_mac_b=io_in_b, io_mac_c=acc. This path is combinational.
  - On input fire: acc<=io_mac_out and cnt<=cnt-1. If cnt==1, go to DONE.
  - With no fire, hold all state.
- DONE:
  - io_res_valid=1 and io_res_bits=acc.
  - On io_res_ready, go to IDLE.
- Outside RUN: io_mac_a=io_mac_b=0 and io_mac_c=acc. io_in_ready=0, so io_in_valid is ignored and no state changes.
- Commands are accepted only in IDLE. There is no overlap between a result drain and the next command.
- Arithmetic is unsigned integer modulo 2^16, identical to the MAC. The block performs no saturation and no overflow flag.
- io_res_bits is 0 whenever io_res_valid is 0.

## Timing
- Reset:
  - Applied at the clock edge: state<=IDLE, acc<=0, cnt<=0.
  - While reset is high, io_cmd_ready, io_in_ready and io_res_valid are forced to 0.
  - All data outputs are 0 during reset.
- First cycle after reset deasserts: io_cmd_ready=1.
- Reset mid-RUN or mid-DONE aborts the operation. No result is produced, and a partial accumulation is discarded.
- Throughput: one element per cycle when io_in_valid is held high.
- Latency: io_res_valid rises the cycle after the Nth input fire. For N==0, it rises the cycle after command fire.
- io_res_bits and io_res_valid stay stable until io_res_ready is sampled high.
- io_cmd_ready returns high the cycle after result fire.
- Simultaneous io_in_valid and io_cmd_valid in RUN: only the input is taken.
- cnt never wraps, because the decrement happens only while cnt>=1.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits);
  - the DATA_W and LEN_W defaults.
- No sub-module inside this block. The MAC is instantiated beside it at the parent level, wired io_mac_a/b/c to MAC a/b/c and MAC out to io_mac_out.
- The bench instantiates this block together with the MAC.

## Test plan
- Basic dot product: cmd len=3, bias=5; pairs (2,3), (4,5), (1,1) back-to-back.
  - Expect io_res_valid 1 cycle after the third fire, with io_res_bits=32.
- Zero length: cmd len=0, bias=0x1234.
  - Expect io_res_valid the next cycle with 0x1234.
  - Expect no io_in_ready assertion at any point.
- Wrap: cmd len=2, bias=0xFFFF; pairs (0x0100,0x0100) then (1,1).
  - Expect acc 0xFFFF after the first pair, then result 0x0000.
- Backpressure and gaps:
  - len=2 with a 2-cycle io_in_valid gap between pairs: expect acc and cnt to hold through the gap.
  - io_res_ready low for 3 cycles: expect io_res_bits stable and io_cmd_ready=0 until the fire, then io_cmd_ready=1 on the next cycle.
- Reset mid-operation: len=3, one pair accepted, then reset for 1 cycle.
  - Next cycle: io_cmd_ready=1, io_res_valid=0, io_busy=0.
  - A new cmd len=1, bias=0 with pair (3,3) yields 9.
- Idle input ignored: io_in_valid=1 with (7,7) while IDLE.
  - Expect io_in_ready=0.
  - A subsequent len=0, bias=0 command returns 0.
